// File: rtl/rotate_seq.sv
// Sequential rotate unit: loads a word, rotates it one position per clock by a
// programmed amount, pulses DONE on completion, and can undo the last rotation.
module rotate_seq #(
  parameter int N = 8,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         CLK,
  input  logic         N_RESET,
  input  logic         LOAD,
  input  logic [N-1:0] DIN,
  input  logic         DIR,
  input  logic [W-1:0] AMT,
  input  logic         UNDO,
  output logic [N-1:0] DOUT,
  output logic         BUSY,
  output logic         DONE,
  output logic         state_dbg_o
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ROTATE = 1'b1
  } state_t;

  // Handshake: LOAD/UNDO are single-cycle requests, accepted only on an edge
  // where BUSY=0; requests seen while BUSY=1 are dropped without any effect.
  state_t         state_q, state_d;
  logic [N-1:0]   dout_q, dout_d;
  logic           dir_q, dir_d;
  logic [W-1:0]   amt_q, amt_d;
  logic [W-1:0]   cnt_q, cnt_d;
  logic           done_q, done_d;
  logic [N-1:0]   dout_step;

  // One-position rotation in the stored direction (0 = left, 1 = right).
  always_comb begin
    if (dir_q) dout_step = {dout_q[0], dout_q[N-1:1]};
    else       dout_step = {dout_q[N-2:0], dout_q[N-1]};
  end

  always_ff @(posedge CLK) begin
    if (!N_RESET) begin
      state_q <= ST_IDLE;
      dout_q  <= '0;
      dir_q   <= 1'b0;
      amt_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dout_q  <= dout_d;
      dir_q   <= dir_d;
      amt_q   <= amt_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dout_d  = dout_q;
    dir_d   = dir_q;
    amt_d   = amt_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (LOAD) begin
          dout_d = DIN;
          dir_d  = DIR;
          amt_d  = AMT;
          cnt_d  = AMT;
          if (AMT != '0) state_d = ST_ROTATE;
          else           done_d  = 1'b1;
        end else if (UNDO) begin
          // Undo replays the stored amount in the opposite direction on the held word.
          dir_d = ~dir_q;
          cnt_d = amt_q;
          if (amt_q != '0) state_d = ST_ROTATE;
          else             done_d  = 1'b1;
        end
      end
      ST_ROTATE: begin
        dout_d = dout_step;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == W'(1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign DOUT        = dout_q;
  assign BUSY        = (state_q == ST_ROTATE);
  assign DONE        = done_q;
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_rotate_seq.sv
// Bench for rotate_seq: directed scenarios with literal expectations plus a
// randomized run compared every cycle against an arithmetic rotation model.
module tb_rotate_seq;
  localparam int N = 8;
  localparam int W = $clog2(N);

  logic         clk;
  logic         n_reset;
  logic         load;
  logic [N-1:0] din;
  logic         dir;
  logic [W-1:0] amt;
  logic         undo;
  logic [N-1:0] dout;
  logic         busy;
  logic         done;
  logic         state_dbg;

  int checks = 0;
  int errors = 0;

  rotate_seq #(.N(N)) dut (
    .CLK(clk), .N_RESET(n_reset), .LOAD(load), .DIN(din), .DIR(dir),
    .AMT(amt), .UNDO(undo), .DOUT(dout), .BUSY(busy), .DONE(done),
    .state_dbg_o(state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Rotate x by k places (mod N) in direction d using a doubled word.
  function automatic logic [N-1:0] rot(input logic [N-1:0] x, input logic d, input int k);
    logic [2*N-1:0] t;
    int kk;
    kk = k % N;
    t  = {x, x};
    if (d) begin
      t = t >> kk;
      return t[N-1:0];
    end
    t = t << kk;
    return t[2*N-1:N];
  endfunction

  // Reference model: word at request time, direction, amount, steps taken.
  logic [N-1:0] m_base;
  logic         m_dir;
  int           m_amt, m_k;
  logic         m_busy, m_done;
  logic         check_en = 1'b0;

  always @(posedge clk) begin
    if (!n_reset) begin
      m_base = '0; m_dir = 1'b0; m_amt = 0; m_k = 0; m_busy = 1'b0; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        m_k = m_k + 1;
        if (m_k == m_amt) begin
          m_busy = 1'b0;
          m_done = 1'b1;
        end
      end else if (load || undo) begin
        if (load) begin
          m_base = din;
          m_dir  = dir;
          m_amt  = int'(amt);
        end else begin
          m_base = rot(m_base, m_dir, m_k);
          m_dir  = ~m_dir;
        end
        m_k = 0;
        if (m_amt == 0) m_done = 1'b1;
        else            m_busy = 1'b1;
      end
    end
  end

  // Scoreboard compare, every cycle once the model has seen a reset edge.
  always @(negedge clk) begin
    if (check_en) begin
      logic [N-1:0] exp_dout;
      exp_dout = rot(m_base, m_dir, m_k);
      checks = checks + 3;
      if (dout !== exp_dout) begin
        errors = errors + 1;
        $display("FAIL model_dout t=%0t got=%b exp=%b", $time, dout, exp_dout);
      end
      if (busy !== m_busy) begin
        errors = errors + 1;
        $display("FAIL model_busy t=%0t got=%b exp=%b", $time, busy, m_busy);
      end
      if (done !== m_done) begin
        errors = errors + 1;
        $display("FAIL model_done t=%0t got=%b exp=%b", $time, done, m_done);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  // Driver tasks: inputs change on the falling edge, sampled on the next rise.
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [N-1:0] d, input logic r, input logic [W-1:0] a);
    load = 1'b1; din = d; dir = r; amt = a;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic do_undo();
    undo = 1'b1;
    @(negedge clk);
    undo = 1'b0;
  endtask

  initial begin
    int saw_done;
    n_reset = 1'b0; load = 1'b0; undo = 1'b0; din = '0; dir = 1'b0; amt = '0;
    cycles(2);
    check_en = 1'b1;
    chk("reset_dout", 32'(dout), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_done", 32'(done), 32'h0);
    n_reset = 1'b1;
    cycles(1);

    // Left rotate by 3
    do_load(8'b10101100, 1'b0, 3'd3);
    chk("l3_busy_e0", 32'(busy), 32'h1);
    cycles(1); chk("l3_e1", 32'(dout), 32'(8'b01011001));
    cycles(1); chk("l3_e2", 32'(dout), 32'(8'b10110010));
    cycles(1); chk("l3_e3", 32'(dout), 32'(8'b01100101));
    chk("l3_done", 32'(done), 32'h1);
    chk("l3_idle", 32'(busy), 32'h0);
    cycles(1); chk("l3_done_drop", 32'(done), 32'h0);

    // Undo, then undo again
    do_undo(); cycles(3);
    chk("undo1_dout", 32'(dout), 32'(8'b10101100));
    chk("undo1_done", 32'(done), 32'h1);
    do_undo(); cycles(3);
    chk("undo2_dout", 32'(dout), 32'(8'b01100101));

    // Right by 1 equals left by 7
    do_load(8'b10101100, 1'b1, 3'd1); cycles(1);
    chk("r1_dout", 32'(dout), 32'(8'b01010110));
    do_load(8'b10101100, 1'b0, 3'd7); cycles(6);
    chk("l7_not_done", 32'(done), 32'h0);
    cycles(1);
    chk("l7_dout", 32'(dout), 32'(8'b01010110));
    chk("l7_done", 32'(done), 32'h1);

    // Zero amount
    do_load(8'hA5, 1'b0, 3'd0);
    chk("a0_dout", 32'(dout), 32'hA5);
    chk("a0_done", 32'(done), 32'h1);
    chk("a0_busy", 32'(busy), 32'h0);

    // LOAD and UNDO together: load wins
    undo = 1'b1;
    do_load(8'b00111100, 1'b1, 3'd2);
    undo = 1'b0;
    cycles(2);
    chk("both_dout", 32'(dout), 32'(8'b00001111));

    // Requests during rotation are ignored
    do_load(8'b10010110, 1'b0, 3'd5); cycles(1);
    load = 1'b1; undo = 1'b1; din = 8'hFF; amt = 3'd1;
    cycles(1);
    load = 1'b0; undo = 1'b0;
    cycles(3);
    chk("ign_dout", 32'(dout), 32'hD2);
    chk("ign_done", 32'(done), 32'h1);

    // Reset mid-rotation: no DONE afterwards
    do_load(8'h5A, 1'b1, 3'd6); cycles(2);
    n_reset = 1'b0; cycles(1);
    chk("rst_mid_dout", 32'(dout), 32'h0);
    chk("rst_mid_busy", 32'(busy), 32'h0);
    n_reset = 1'b1;
    saw_done = 0;
    for (int i = 0; i < 8; i++) begin
      cycles(1);
      if (done) saw_done = 1;
    end
    chk("rst_mid_no_done", 32'(saw_done), 32'h0);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      load    = ($urandom_range(0, 3) == 0);
      undo    = ($urandom_range(0, 3) == 0);
      din     = N'($urandom);
      dir     = 1'($urandom_range(0, 1));
      amt     = W'($urandom_range(0, N - 1));
      n_reset = ($urandom_range(0, 99) != 0);
      cycles(1);
    end
    load = 1'b0; undo = 1'b0; n_reset = 1'b1;
    cycles(N + 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rotate_seq.md
# rotate_seq

Sequential rotate unit: loads an N-bit word and rotates it one bit position per clock, left or right, by a programmed amount. It signals completion with a one-cycle pulse. An UNDO request rotates the held result back by the same amount in the opposite direction, restoring the original word. It is the clocked, multi-cycle counterpart of the combinational single-step `rotateN` rotator, for use wherever rotation must be paced by the system clock.

## Interface
- N, 8, word width (N ≥ 2)
- W, $clog2(N), width of rotate amount (localparam)

- CLK  in  1  system clock, all state updates on rising edge
- N_RESET  in  1  synchronous active-low reset
- LOAD  in  1  start request; sampled only when BUSY=0
- DIN  in  N  word to rotate, captured with LOAD
- DIR  in  1  direction captured with LOAD: 0 = left (MSB wraps to LSB), 1 = right (LSB wraps to MSB)
- AMT  in  W  rotate amount 0..N-1, captured with LOAD
- UNDO  in  1  reverse last operation; sampled only when BUSY=0
- DOUT  out  N  working/result register
- BUSY  out  1  high while rotation steps remain
- DONE  out  1  one-cycle completion pulse

## Operation
- Reset is synchronous and active-low: one clock and one synchronous active-low reset. A rising CLK edge with N_RESET=0 forces the following:
  - DOUT=0, BUSY=0, DONE=0.
  - Stored direction=0, stored amount=0, step counter=0, state IDLE.
- Reset overrides everything, including mid-rotation; any rotation in progress is aborted with no DONE pulse.
- States:
  - IDLE: BUSY=0, accepts LOAD/UNDO.
  - ROTATE: BUSY=1, one rotation step per edge.
- IDLE, LOAD=1:
  - DOUT←DIN.
  - Stored dir←DIR, stored amt←AMT, counter←AMT.
  - If AMT≠0 → ROTATE. If AMT=0 → stay IDLE and DONE←1.
- IDLE, UNDO=1, LOAD=0:
  - Stored dir←~stored dir, counter←stored amt; DOUT is not reloaded.
  - If stored amt≠0 → ROTATE, else DONE←1.
- LOAD and UNDO both high in IDLE: LOAD wins, UNDO is ignored.
- ROTATE, each edge:
  - DOUT←DOUT rotated by 1 in stored dir; counter←counter−1.
  - When counter=1 on that edge → IDLE, BUSY←0, DONE←1.
- LOAD/UNDO while BUSY=1: ignored entirely, with no effect on DIN capture or on the counter.
- After an UNDO completes, stored dir remains inverted, so a second UNDO re-applies the original rotation.
- DONE is registered and is high for exactly one cycle per accepted LOAD/UNDO. It is otherwise 0.
- Rotation is modulo N; AMT values are always < N by width when N is a power of 2. For non-power-of-2 N, AMT ≥ N is treated literally (AMT single steps).

## Timing
- E0 = edge sampling an accepted LOAD/UNDO; BUSY is high after E0 iff amount≠0.
- Rotation edges are E1..E_AMT. After E_k, DOUT is rotated k places.
- DONE is high in the cycle following E_AMT. For AMT=0, DONE is high in the cycle following E0, with DOUT=DIN.
- Total latency from request edge to DONE is AMT cycles (minimum 0 extra; DONE follows E0 for AMT=0).
- A new LOAD may be sampled on the same edge at which DONE is visible, i.e. the edge after E_AMT (back-to-back throughput: AMT+1 edges per operation).
- DOUT holds its value in IDLE indefinitely.

## Test plan
- Reset, then LOAD DIN=8'b10101100, DIR=0, AMT=3 → after E1, E2, E3:
  - DOUT = 01011001, 10110010, 01100101 respectively.
  - BUSY high 3 cycles; DONE single pulse after E3.
- Continuing from the previous scenario, UNDO → 3 cycles later DOUT=10101100, DONE pulse. A second UNDO → DOUT=01100101.
- LOAD 10101100, DIR=1, AMT=1 → DOUT=01010110 after E1. LOAD 10101100, DIR=0, AMT=7 → same 01010110 after E7, DONE after E7.
- LOAD with AMT=0, DIN=8'hA5 → DOUT=A5 and DONE after E0, BUSY never high. LOAD and UNDO together in IDLE → LOAD behaviour only.
- During AMT=5 rotation, pulse LOAD with DIN=8'hFF and UNDO → ignored, and the result equals the undisturbed rotation. Assert N_RESET=0 at step 2 → next cycle DOUT=0, BUSY=0, no DONE pulse ever.
